// File: rtl/alu_seq_muldiv_riscv_if.sv
// alu_seq_muldiv_riscv_if: handshake, operand and result bundle between register-read, ALU and writeback
interface alu_seq_muldiv_riscv_if #(
   parameter int XLEN = 64
);
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_opr;
   logic [XLEN-1:0] ip_data1;
   logic [XLEN-1:0] ip_data2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] op_data;
   logic            branch_taken;
   logic            busy;
   modport master (
      output in_valid, alu_opr, ip_data1, ip_data2, out_ready,
      input  in_ready, out_valid, op_data, branch_taken, busy
   );
   modport slave (
      input  in_valid, alu_opr, ip_data1, ip_data2, out_ready,
      output in_ready, out_valid, op_data, branch_taken, busy
   );
endinterface

// File: rtl/alu_seq_muldiv_riscv.sv
// alu_seq_muldiv_riscv: handshaked RISC-V ALU with single-cycle ops, branch compares and iterative mul/div/rem
module alu_seq_muldiv_riscv #(
   parameter int XLEN    = 64,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   alu_seq_muldiv_riscv_if.slave bus
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
   state_t          r_state, w_next;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_acc, r_opb, r_opc, r_op_data;
   logic            r_taken, r_neg_q, r_neg_r, r_is_rem;
   logic [XLEN-1:0] w_a, w_b, w_abs_a, w_abs_b, w_res;
   logic [SHAMT_W-1:0] w_shamt;
   logic            w_accept, w_taken, w_lt, w_is_mul, w_is_div, w_div_zero, w_div_ovf, w_last;
   logic [XLEN-1:0] w_mul_acc, w_rem_nx, w_quo_nx, w_div_res;
   logic [XLEN:0]   w_div_sh, w_div_sub;
   logic            w_div_ok;
   assign w_a        = bus.ip_data1;
   assign w_b        = bus.ip_data2;
   assign w_shamt    = w_b[SHAMT_W-1:0];
   assign w_accept   = bus.in_valid && r_state == S_IDLE;
   assign w_lt       = $signed(w_a) < $signed(w_b);
   assign w_is_mul   = bus.alu_opr == 4'hD;
   assign w_is_div   = bus.alu_opr[3:1] == 3'b111;
   assign w_div_zero = w_b == '0;
   assign w_div_ovf  = w_a == MIN_NEG && w_b == '1;
   assign w_abs_a    = w_a[XLEN-1] ? -w_a : w_a;
   assign w_abs_b    = w_b[XLEN-1] ? -w_b : w_b;
   assign w_last     = r_cnt == CW'(XLEN - 1);
   // one shift-add step: r_opb is the shifted multiplicand, r_opc the multiplier shifting right
   assign w_mul_acc  = r_acc + (r_opc[0] ? r_opb : '0);
   // one restoring step: r_acc is the partial remainder, r_opc shifts the dividend out and the quotient in
   assign w_div_sh   = {r_acc, r_opc[XLEN-1]};
   assign w_div_sub  = w_div_sh - {1'b0, r_opb};
   assign w_div_ok   = !w_div_sub[XLEN];
   assign w_rem_nx   = w_div_ok ? w_div_sub[XLEN-1:0] : w_div_sh[XLEN-1:0];
   assign w_quo_nx   = {r_opc[XLEN-2:0], w_div_ok};
   assign w_div_res  = r_is_rem ? (r_neg_r ? -w_rem_nx : w_rem_nx) : (r_neg_q ? -w_quo_nx : w_quo_nx);
   assign bus.in_ready     = r_state == S_IDLE;
   assign bus.out_valid    = r_state == S_DONE;
   assign bus.busy         = r_state != S_IDLE;
   assign bus.op_data      = r_op_data;
   assign bus.branch_taken = r_taken;
   // single-cycle result and branch condition; div special cases resolve here without iterating
   always_comb begin
      w_res   = '0;
      w_taken = 1'b0;
      case (bus.alu_opr)
         4'h0: w_res = w_a + w_b;
         4'h1: w_res = w_a - w_b;
         4'h2: w_res = w_a << w_shamt;
         4'h3: w_res = w_a ^ w_b;
         4'h4: w_res = w_a >> w_shamt;
         4'h5: w_res = w_a | w_b;
         4'h6: w_res = w_a & w_b;
         4'h7: w_taken = w_a == w_b;
         4'h8: w_taken = w_a != w_b;
         4'h9: w_taken = w_lt;
         4'hA: w_taken = !w_lt;
         4'hB: w_res = $signed(w_a) >>> w_shamt;
         4'hC: w_res = {{(XLEN-1){1'b0}}, w_lt};
         4'hE: w_res = w_div_zero ? '1 : w_a;
         4'hF: w_res = w_div_zero ? w_a : '0;
         default: ;
      endcase
   end
   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end
   // next state: mul/div iterate XLEN cycles, special divides and everything else finish at once
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (bus.in_valid) w_next = w_is_mul ? S_MUL : (w_is_div && !w_div_zero && !w_div_ovf) ? S_DIV : S_DONE;
         S_MUL, S_DIV: if (w_last) w_next = S_DONE;
         S_DONE:       if (bus.out_ready) w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end
   // datapath: capture operands on accept, step the iterative unit, hold the result in DONE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_opb     <= '0;
         r_opc     <= '0;
         r_op_data <= '0;
         r_taken   <= 1'b0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_is_rem  <= 1'b0;
      end else if (w_accept) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_opb     <= w_is_mul ? w_a : w_abs_b;
         r_opc     <= w_is_mul ? w_b : w_abs_a;
         r_op_data <= w_res;
         r_taken   <= w_taken;
         r_neg_q   <= w_a[XLEN-1] ^ w_b[XLEN-1];
         r_neg_r   <= w_a[XLEN-1];
         r_is_rem  <= bus.alu_opr[0];
      end else if (r_state == S_MUL) begin
         r_cnt <= r_cnt + 1'b1;
         r_acc <= w_mul_acc;
         r_opb <= {r_opb[XLEN-2:0], 1'b0};
         r_opc <= {1'b0, r_opc[XLEN-1:1]};
         if (w_last) r_op_data <= w_mul_acc;
      end else if (r_state == S_DIV) begin
         r_cnt <= r_cnt + 1'b1;
         r_acc <= w_rem_nx;
         r_opc <= w_quo_nx;
         if (w_last) r_op_data <= w_div_res;
      end
   end
endmodule

// File: tb/tb_alu_seq_muldiv_riscv.sv
// tb_alu_seq_muldiv_riscv: directed checks of ALU results, latency, back-pressure and reset
module tb_alu_seq_muldiv_riscv;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   alu_seq_muldiv_riscv_if #(.XLEN(64)) bus ();
   alu_seq_muldiv_riscv #(.XLEN(64)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask
   task automatic run(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] exp_d, input logic exp_t, input int exp_lat, input int hold);
      int lat;
      bus.in_valid = 1'b1;
      bus.alu_opr  = op;
      bus.ip_data1 = a;
      bus.ip_data2 = b;
      @(posedge clk); #1;
      bus.alu_opr  = op ^ 4'h5;
      bus.ip_data1 = ~a;
      bus.ip_data2 = b + 64'd3;
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         if (lat == 20) chk({tag, "_busy"}, {62'b0, bus.busy, bus.in_ready}, 64'h2);
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      repeat (hold) begin @(posedge clk); #1; end
      bus.in_valid = 1'b0;
      chk({tag, "_data"}, bus.op_data, exp_d);
      chk({tag, "_taken"}, {63'b0, bus.branch_taken}, {63'b0, exp_t});
      chk({tag, "_valid"}, {63'b0, bus.out_valid}, 64'd1);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({tag, "_idle"}, {62'b0, bus.in_ready, bus.out_valid}, 64'h2);
   endtask
   initial begin
      int seen;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.alu_opr   = 4'h0;
      bus.ip_data1  = '0;
      bus.ip_data2  = '0;
      #12;
      chk("rst_flags", {60'b0, bus.in_ready, bus.out_valid, bus.busy, bus.branch_taken}, 64'h8);
      chk("rst_data", bus.op_data, 64'h0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      run("add_ovf", 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, MINV, 1'b0, 1, 0);
      run("sub",     4'h1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1, 0);
      run("sll",     4'h2, 64'd1, 64'h41, 64'd2, 1'b0, 1, 0);
      run("xor",     4'h3, 64'hF0F0, 64'h0FF0, 64'hFF00, 1'b0, 1, 0);
      run("srl",     4'h4, MINV, 64'd63, 64'd1, 1'b0, 1, 0);
      run("or",      4'h5, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1, 0);
      run("and",     4'h6, 64'hF0, 64'h3C, 64'h30, 1'b0, 1, 0);
      run("beq",     4'h7, 64'd5, 64'd5, 64'd0, 1'b1, 1, 0);
      run("bne",     4'h8, 64'd5, 64'd5, 64'd0, 1'b0, 1, 0);
      run("blt",     4'h9, ONES, 64'd1, 64'd0, 1'b1, 1, 0);
      run("bge",     4'hA, ONES, 64'd1, 64'd0, 1'b0, 1, 0);
      run("sra",     4'hB, MINV, 64'd63, ONES, 1'b0, 1, 0);
      run("slt_t",   4'hC, ONES, 64'd1, 64'd1, 1'b0, 1, 0);
      run("slt_f",   4'hC, 64'd1, ONES, 64'd0, 1'b0, 1, 0);
      run("mul_neg", 4'hD, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 65, 0);
      run("mul_big", 4'hD, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 65, 0);
      run("div_neg", 4'hE, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65, 0);
      run("rem_neg", 4'hF, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 1'b0, 65, 0);
      run("div_nd",  4'hE, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65, 0);
      run("rem_nd",  4'hF, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0, 65, 10);
      run("div_z",   4'hE, 64'd100, 64'd0, ONES, 1'b0, 1, 0);
      run("rem_z",   4'hF, 64'd9, 64'd0, 64'd9, 1'b0, 1, 10);
      run("div_min", 4'hE, MINV, ONES, MINV, 1'b0, 1, 0);
      run("rem_min", 4'hF, MINV, ONES, 64'd0, 1'b0, 1, 0);
      run("sll_hold", 4'h2, 64'h3, 64'd4, 64'h30, 1'b0, 1, 10);
      bus.in_valid = 1'b1;
      bus.alu_opr  = 4'hD;
      bus.ip_data1 = 64'hFFFF_FFFF_FFFF_FFFD;
      bus.ip_data2 = 64'd7;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (19) begin @(posedge clk); #1; end
      chk("mid_busy", {63'b0, bus.busy}, 64'd1);
      reset_n = 1'b0;
      #1;
      chk("arst_flags", {60'b0, bus.in_ready, bus.out_valid, bus.busy, bus.branch_taken}, 64'h8);
      chk("arst_data", bus.op_data, 64'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      seen = 0;
      repeat (70) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      chk("arst_no_out", 64'(seen), 64'd0);
      run("post_rst", 4'h0, 64'd2, 64'd3, 64'd5, 1'b0, 1, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
